sound_sample_player: RTL and testbench

- Avalon-MM read master that streams a stored sound effect out of a 16-bit single-port on-chip sample ROM (e.g. tank explosion, 13000 words), one word per sample.
- Paces the samples onto an Avalon-ST sink feeding the audio codec path.
- Sits between the sound ROMs and the audio output mixer. Triggered by the game-logic register block.
- Handles ROM read latency, prefetch buffering, sample-rate upscaling (sample repeat), restart and abort.

---
 rtl/sound_pkg.sv | 15 +
 rtl/sample_fifo.sv | 49 ++++
 rtl/sound_sample_player.sv | 118 +++++++++++
 tb/tb_sound_sample_player.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared constants for the sound ROM players: default widths, effect lengths
// and the player state encoding.
package sound_pkg;
  localparam int SND_ADDR_W    = 14;
  localparam int SND_DATA_W    = 16;
  localparam int EXPLODE_WORDS = 13000;
  localparam int FIRE_WORDS    = 4200;
  localparam int MOVE_WORDS    = 2600;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DRAIN = 2'd2
  } player_state_e;
endpackage

// File: rtl/sample_fifo.sv
// Two-entry sample FIFO with write-through: an incoming word is visible at the
// head in the same cycle it is pushed when the FIFO is empty.
module sample_fifo #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [1:0]        count_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);
  logic [DATA_W-1:0] mem_q [2];
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              empty, store, deq, wr_ptr;

  always_comb begin
    empty   = (count_q == 2'd0);
    valid_o = !empty || push_i;
    data_o  = '0;
    if (!empty) data_o = mem_q[rd_ptr_q];
    else if (push_i) data_o = push_data_i;
    // A word consumed straight from the bypass path is never stored.
    store   = push_i && !(empty && pop_i);
    deq     = pop_i && !empty;
    wr_ptr  = rd_ptr_q ^ (count_q == 2'd1);
    count_o = count_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (flush_i) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (store) mem_q[wr_ptr] <= push_data_i;
      if (deq) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, store} - {1'b0, deq};
    end
  end
endmodule

// File: rtl/sound_sample_player.sv
// Streams a sound effect from a latency-1 sample ROM onto an Avalon-ST sink,
// repeating each ROM word REPEAT times. Handshake: a sample transfers in any
// cycle where sample_valid && sample_ready; data/valid hold while stalled.
module sound_sample_player import sound_pkg::*; #(
  parameter int ADDR_W    = SND_ADDR_W,
  parameter int DATA_W    = SND_DATA_W,
  parameter int NUM_WORDS = EXPLODE_WORDS,
  parameter int REPEAT    = 6,
  parameter int LOOP      = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trigger,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_chipselect,
  output logic              rom_clken,
  input  logic [DATA_W-1:0] rom_readdata,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output player_state_e     dbg_state
);
  localparam int RPT_W = $clog2(REPEAT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [RPT_W-1:0]  LAST_RPT  = RPT_W'(REPEAT - 1);

  if (NUM_WORDS > (1 << ADDR_W) || NUM_WORDS < 1 || REPEAT < 1) begin : g_bad_params
    $error("sound_sample_player: bad NUM_WORDS/REPEAT for ADDR_W");
  end

  player_state_e     state_q, state_d;
  logic [ADDR_W-1:0] fetch_q, fetch_d;
  logic [RPT_W-1:0]  rpt_q, rpt_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;

  logic [1:0] fifo_count;
  logic [2:0] occupancy;
  logic       issue, hs, pop, flush;

  sample_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .flush_i     (flush),
    .push_i      (inflight_q),
    .push_data_i (rom_readdata),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .valid_o     (sample_valid),
    .data_o      (sample_data)
  );

  always_comb begin
    occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q};
    issue      = (state_q == ST_PLAY) && (occupancy < 3'd2);
    hs         = sample_valid && sample_ready;
    pop        = hs && (rpt_q == LAST_RPT);
    flush      = trigger || (stop && (state_q != ST_IDLE));

    state_d    = state_q;
    fetch_d    = fetch_q;
    rpt_d      = rpt_q;
    inflight_d = issue;
    done_d     = 1'b0;

    if (hs) rpt_d = pop ? '0 : rpt_q + RPT_W'(1);
    if (issue) begin
      if (fetch_q == LAST_ADDR && LOOP != 0) fetch_d = '0;
      else fetch_d = fetch_q + ADDR_W'(1);
      if (fetch_q == LAST_ADDR && LOOP == 0) state_d = ST_DRAIN;
    end
    // Only the last word remains once nothing else is buffered or in flight.
    if (state_q == ST_DRAIN && pop && occupancy == 3'd1) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end

    if (trigger) begin
      state_d    = ST_PLAY;
      fetch_d    = '0;
      rpt_d      = '0;
      inflight_d = 1'b0;
      done_d     = 1'b0;
    end else if (stop && state_q != ST_IDLE) begin
      state_d    = ST_IDLE;
      fetch_d    = '0;
      rpt_d      = '0;
      inflight_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      fetch_q    <= '0;
      rpt_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_q    <= fetch_d;
      rpt_q      <= rpt_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign rom_chipselect = issue;
  assign rom_clken      = issue;
  assign rom_address    = issue ? fetch_q : '0;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_sound_sample_player.sv
// Bench for sound_sample_player: one one-shot instance (8 words, repeat 2) and
// one looping instance (4 words, repeat 1), each with its own ROM model.
module tb_sound_sample_player;
  import sound_pkg::*;

  localparam int N_A = 8;
  localparam int R_A = 2;
  localparam int N_B = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_trig = 0, a_stop = 0, a_ready = 1;
  logic        a_busy, a_done, a_cs, a_clken, a_valid;
  logic [3:0]  a_addr;
  logic [15:0] a_rd = '0, a_data;
  player_state_e a_state;

  logic        b_trig = 0, b_stop = 0, b_ready = 1;
  logic        b_busy, b_done, b_cs, b_clken, b_valid;
  logic [1:0]  b_addr;
  logic [15:0] b_rd = '0, b_data;
  player_state_e b_state;

  sound_sample_player #(.ADDR_W(4), .DATA_W(16), .NUM_WORDS(N_A), .REPEAT(R_A), .LOOP(0)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .trigger(a_trig), .stop(a_stop), .busy(a_busy), .done(a_done),
    .rom_address(a_addr), .rom_chipselect(a_cs), .rom_clken(a_clken), .rom_readdata(a_rd),
    .sample_data(a_data), .sample_valid(a_valid), .sample_ready(a_ready), .dbg_state(a_state));

  sound_sample_player #(.ADDR_W(2), .DATA_W(16), .NUM_WORDS(N_B), .REPEAT(1), .LOOP(1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .trigger(b_trig), .stop(b_stop), .busy(b_busy), .done(b_done),
    .rom_address(b_addr), .rom_chipselect(b_cs), .rom_clken(b_clken), .rom_readdata(b_rd),
    .sample_data(b_data), .sample_valid(b_valid), .sample_ready(b_ready), .dbg_state(b_state));

  function automatic logic [15:0] rom_val(input int i);
    return 16'(i * 'h111);
  endfunction

  always_ff @(posedge clk) begin
    if (a_cs) a_rd <= rom_val(int'(a_addr));
    if (b_cs) b_rd <= rom_val(int'(b_addr));
  end

  // Scoreboard / model state
  logic [15:0] exp_q[$];
  int n_chk = 0, n_pass = 0;
  int cyc = 0, last_hs_cyc = -10;
  int issued = 0, hs_cnt = 0, done_cnt = 0, max_out = 0;
  int clken_bad = 0, range_bad = 0, b_done_cnt = 0;
  bit bp_en = 0, prev_stall = 0;
  logic [15:0] prev_data = '0;

  typedef struct {
    bit bp;
    int kind;      // 0 plain, 1 restart, 2 trigger+stop collision
    int k;         // handshakes before the restart
    int exp_hs;
    int exp_done;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  task automatic reset_model();
    exp_q.delete();
    for (int i = 0; i < N_A; i++)
      for (int r = 0; r < R_A; r++) exp_q.push_back(rom_val(i));
    issued = 0; hs_cnt = 0; done_cnt = 0; max_out = 0; prev_stall = 0;
  endtask

  task automatic observe();
    int outstanding;
    if (a_clken !== a_cs) clken_bad++;
    if (a_cs && int'(a_addr) >= N_A) range_bad++;
    if (a_cs) issued++;
    if (prev_stall) begin
      chk("stall_valid", int'(a_valid), 1);
      chk("stall_data", int'(a_data), int'(prev_data));
    end
    if (a_valid && a_ready) begin
      if (exp_q.size() == 0) chk("extra_sample", 1, 0);
      else chk("sample", int'(a_data), int'(exp_q.pop_front()));
      hs_cnt++;
      last_hs_cyc = cyc;
    end
    outstanding = issued - hs_cnt / R_A;
    if (outstanding > max_out) max_out = outstanding;
    if (a_done) begin
      done_cnt++;
      chk("done_busy", int'(a_busy), 0);
      chk("done_timing", cyc, last_hs_cyc + 1);
    end
    if (b_done) b_done_cnt++;
    prev_stall = a_valid && !a_ready && !a_trig && !a_stop;
    prev_data = a_data;
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
    a_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic fire_trigger(input bit with_stop);
    a_trig = 1; a_stop = with_stop;
    tick();
    a_trig = 0; a_stop = 0;
    reset_model();
    chk("start_busy", int'(a_busy), 1);
    chk("start_cs", int'(a_cs), 1);
    chk("start_addr", int'(a_addr), 0);
    chk("start_valid", int'(a_valid), 0);
    tick();
    chk("first_valid", int'(a_valid), 1);
    chk("first_data", int'(a_data), int'(rom_val(0)));
  endtask

  task automatic wait_hs(input int k);
    int budget = 500;
    while (hs_cnt < k && budget > 0) begin tick(); budget--; end
    if (budget == 0) chk("timeout_hs", 0, 1);
  endtask

  task automatic run_play(input vec_t v);
    int budget = 1000;
    bp_en = v.bp;
    fire_trigger(0);
    if (v.kind != 0) begin
      wait_hs(v.k);
      fire_trigger(v.kind == 2);
    end
    while (done_cnt == 0 && budget > 0) begin tick(); budget--; end
    if (budget == 0) chk("timeout_done", 0, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("run_hs", hs_cnt, v.exp_hs);
    chk("run_done", done_cnt, v.exp_done);
    chk("run_left", exp_q.size(), 0);
    chk("run_outstanding", int'(max_out <= 2), 1);
    chk("run_idle", int'(a_busy), 0);
    bp_en = 0;
  endtask

  task automatic run_stop();
    bp_en = 0;
    fire_trigger(0);
    wait_hs(5);
    a_stop = 1;
    tick();
    a_stop = 0;
    chk("stop_busy", int'(a_busy), 0);
    chk("stop_valid", int'(a_valid), 0);
    chk("stop_cs", int'(a_cs), 0);
    for (int i = 0; i < 5; i++) tick();
    chk("stop_no_done", done_cnt, 0);
  endtask

  task automatic run_loop();
    b_trig = 1;
    tick();
    b_trig = 0;
    chk("loop_busy", int'(b_busy), 1);
    chk("loop_valid0", int'(b_valid), 0);
    tick();
    for (int j = 0; j < 3 * N_B; j++) begin
      chk("loop_valid", int'(b_valid), 1);
      chk("loop_data", int'(b_data), int'(rom_val(j % N_B)));
      tick();
    end
    b_stop = 1;
    tick();
    b_stop = 0;
    chk("loop_stop_busy", int'(b_busy), 0);
    chk("loop_stop_valid", int'(b_valid), 0);
    for (int i = 0; i < 3; i++) tick();
    chk("loop_no_done", b_done_cnt, 0);
  endtask

  initial begin
    vecs.push_back('{0, 0, 0, N_A * R_A, 1});
    vecs.push_back('{1, 0, 0, N_A * R_A, 1});
    vecs.push_back('{0, 1, 6, N_A * R_A, 1});
    vecs.push_back('{1, 1, 7, N_A * R_A, 1});
    vecs.push_back('{0, 2, 4, N_A * R_A, 1});
    vecs.push_back('{1, 2, 9, N_A * R_A, 1});

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1;
    tick();

    // Mid-cycle asynchronous reset while playing.
    fire_trigger(0);
    repeat (3) tick();
    #2;
    reset_n = 0;
    #1;
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_done", int'(a_done), 0);
    chk("rst_cs", int'(a_cs), 0);
    chk("rst_clken", int'(a_clken), 0);
    chk("rst_addr", int'(a_addr), 0);
    chk("rst_valid", int'(a_valid), 0);
    chk("rst_data", int'(a_data), 0);
    chk("rst_state", int'(a_state), int'(ST_IDLE));
    tick();
    reset_n = 1;
    reset_model();
    repeat (10) tick();
    chk("idle_no_reads", issued, 0);

    foreach (vecs[i]) run_play(vecs[i]);
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v.bp = 1'($urandom_range(0, 1));
      v.kind = int'($urandom_range(0, 2));
      v.k = int'($urandom_range(1, N_A * R_A - 2));
      v.exp_hs = N_A * R_A;
      v.exp_done = 1;
      run_play(v);
    end
    run_stop();
    run_loop();

    chk("clken_eq_cs", clken_bad, 0);
    chk("addr_range", range_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
